// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesting masters and the round-robin arbiter.
// The master side drives requests; the slave side (the arbiter) drives the grant signals.
interface rr_grant_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic               busy;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  busy
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output busy
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for NUM_REQ requesters with a bounded hold time under contention
// and a one-cycle dead gap between successive owners. All outputs are registered.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | no owner, waiting for any request
// ST_GRANT   | one requester owns the resource, hold counter running
// ST_RELEASE | one-cycle dead gap, last_ptr already points at departing owner
module rr_grant_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input logic          clock,
  input logic          reset,
  rr_grant_arbiter_if.slave bus
);

  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("rr_grant_arbiter: ID_W must equal clog2(NUM_REQ)");
  end
  if (MAX_HOLD > (2 ** HOLD_W) - 1) begin : g_bad_hold_w
    $error("rr_grant_arbiter: MAX_HOLD does not fit in HOLD_W bits");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [ID_W-1:0]   LAST_INIT  = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]     NUM_REQ_W  = (ID_W + 1)'(NUM_REQ);
  localparam bit                PREEMPT_EN = (MAX_HOLD != 0);
  // With preemption disabled the counter simply saturates at all-ones and is never consulted.
  localparam logic [HOLD_W-1:0] HOLD_LAST  = PREEMPT_EN ? HOLD_W'(MAX_HOLD - 1) : {HOLD_W{1'b1}};

  state_t              state;
  logic [ID_W-1:0]     last_ptr;
  logic [HOLD_W-1:0]   hold_cnt;

  logic [ID_W:0]       cand_sum;
  logic [ID_W-1:0]     cand_id;
  logic [ID_W-1:0]     win_id;
  logic                win_found;
  logic [NUM_REQ-1:0]  win_onehot;
  logic                owner_req;
  logic                others_waiting;
  logic                hold_expired;

  // Search upward from last_ptr+1, wrapping modulo NUM_REQ; last_ptr itself is tried last.
  always_comb begin
    cand_sum  = '0;
    cand_id   = '0;
    win_id    = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_sum = {1'b0, last_ptr} + (ID_W + 1)'(k);
      if (cand_sum >= NUM_REQ_W) begin
        cand_sum = cand_sum - NUM_REQ_W;
      end
      cand_id = cand_sum[ID_W-1:0];
      if (!win_found && bus.req[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  always_comb begin
    win_onehot     = NUM_REQ'(1) << win_id;
    owner_req      = bus.req[bus.gnt_id];
    others_waiting = |(bus.req & ~bus.gnt);
    hold_expired   = PREEMPT_EN && (hold_cnt == HOLD_LAST) && others_waiting;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      bus.gnt       <= '0;
      bus.gnt_valid <= 1'b0;
      bus.gnt_id    <= '0;
      bus.busy      <= 1'b0;
      last_ptr      <= LAST_INIT;
      hold_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            state         <= ST_GRANT;
            bus.gnt       <= win_onehot;
            bus.gnt_valid <= 1'b1;
            bus.gnt_id    <= win_id;
            bus.busy      <= 1'b1;
            hold_cnt      <= '0;
          end
        end

        ST_GRANT: begin
          // An owner drop and an expired hold lead to the same release path.
          if (!owner_req || hold_expired) begin
            state         <= ST_RELEASE;
            bus.gnt       <= '0;
            bus.gnt_valid <= 1'b0;
            last_ptr      <= bus.gnt_id;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (win_found) begin
            state         <= ST_GRANT;
            bus.gnt       <= win_onehot;
            bus.gnt_valid <= 1'b1;
            bus.gnt_id    <= win_id;
            hold_cnt      <= '0;
          end else begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end

        default: begin
          state         <= ST_IDLE;
          bus.gnt       <= '0;
          bus.gnt_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: one instance with MAX_HOLD=8, one with preemption off.
module tb_rr_grant_arbiter;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  rr_grant_arbiter_if #(.NUM_REQ(4), .ID_W(2)) ba ();
  rr_grant_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bb ();

  rr_grant_arbiter #(.NUM_REQ(4), .ID_W(2), .MAX_HOLD(8), .HOLD_W(4)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ba.slave)
  );

  rr_grant_arbiter #(.NUM_REQ(4), .ID_W(2), .MAX_HOLD(0), .HOLD_W(4)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bb.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int exp_gnt;

    reset  = 1'b1;
    ba.req = 4'b0000;
    bb.req = 4'b0000;
    #22;
    check("rst_a_gnt",   32'(ba.gnt),       32'h0);
    check("rst_a_valid", 32'(ba.gnt_valid), 32'h0);
    check("rst_a_id",    32'(ba.gnt_id),    32'h0);
    check("rst_a_busy",  32'(ba.busy),      32'h0);
    check("rst_b_gnt",   32'(bb.gnt),       32'h0);
    check("rst_b_busy",  32'(bb.busy),      32'h0);
    reset = 1'b0;
    tick();
    check("idle_a_gnt", 32'(ba.gnt), 32'h0);

    // Single request, one-clock latency.
    ba.req = 4'b0100;
    tick();
    check("t1_gnt",   32'(ba.gnt),       32'h4);
    check("t1_id",    32'(ba.gnt_id),    32'h2);
    check("t1_valid", 32'(ba.gnt_valid), 32'h1);
    check("t1_busy",  32'(ba.busy),      32'h1);
    ba.req = 4'b0000;
    tick();
    check("t1_rel_gnt",  32'(ba.gnt),  32'h0);
    check("t1_rel_busy", 32'(ba.busy), 32'h1);
    tick();
    check("t1_idle_busy",  32'(ba.busy),      32'h0);
    check("t1_idle_valid", 32'(ba.gnt_valid), 32'h0);
    check("t1_idle_id",    32'(ba.gnt_id),    32'h2);

    // Full contention after reset: order 0,1,2,3,0, 8 cycles each, 1-cycle gaps.
    #3 reset = 1'b1;
    #3 reset = 1'b0;
    ba.req = 4'b1111;
    tick();
    for (int c = 0; c < 45; c++) begin
      exp_gnt = ((c % 9) == 8) ? 0 : (1 << ((c / 9) % 4));
      check($sformatf("t2_gnt_c%0d", c), 32'(ba.gnt), exp_gnt);
      if (c < 44) tick();
    end
    check("t2_gap_valid", 32'(ba.gnt_valid), 32'h0);
    ba.req = 4'b0000;
    tick();
    check("t2_idle_busy", 32'(ba.busy), 32'h0);

    // Lone requester holds 50 cycles without preemption (last_ptr=0, so 1 wins).
    ba.req = 4'b0010;
    tick();
    for (int i = 0; i < 50; i++) begin
      check($sformatf("t3_hold_%0d", i), 32'(ba.gnt), 32'h2);
      if (i < 49) tick();
    end
    ba.req = 4'b0000;
    tick();
    check("t3_rel_gnt",  32'(ba.gnt),  32'h0);
    check("t3_rel_busy", 32'(ba.busy), 32'h1);
    tick();
    check("t3_idle_busy",  32'(ba.busy),      32'h0);
    check("t3_idle_valid", 32'(ba.gnt_valid), 32'h0);
    check("t3_idle_id",    32'(ba.gnt_id),    32'h1);

    // Owner 1 with 0 and 3 pending; 3 precedes 0 after last_ptr=1.
    ba.req = 4'b0010;
    tick();
    check("t4_gnt1", 32'(ba.gnt), 32'h2);
    ba.req = 4'b1011;
    tick();
    check("t4_noalter_a", 32'(ba.gnt), 32'h2);
    tick();
    check("t4_noalter_b", 32'(ba.gnt), 32'h2);
    ba.req = 4'b1001;
    tick();
    check("t4_gap_gnt",   32'(ba.gnt),       32'h0);
    check("t4_gap_valid", 32'(ba.gnt_valid), 32'h0);
    tick();
    check("t4_next_gnt", 32'(ba.gnt),    32'h8);
    check("t4_next_id",  32'(ba.gnt_id), 32'h3);

    // Asynchronous reset mid-grant, then restart from requester 0.
    #3 reset = 1'b1;
    #1;
    check("t5_async_gnt",   32'(ba.gnt),       32'h0);
    check("t5_async_id",    32'(ba.gnt_id),    32'h0);
    check("t5_async_valid", 32'(ba.gnt_valid), 32'h0);
    check("t5_async_busy",  32'(ba.busy),      32'h0);
    ba.req = 4'b1010;
    #2 reset = 1'b0;
    tick();
    check("t5_restart_gnt", 32'(ba.gnt),    32'h2);
    check("t5_restart_id",  32'(ba.gnt_id), 32'h1);
    ba.req = 4'b0000;
    tick();
    tick();

    // Preemption disabled: requester 0 keeps ownership under contention.
    bb.req = 4'b0011;
    tick();
    check("t6_gnt0", 32'(bb.gnt), 32'h1);
    for (int i = 0; i < 20; i++) tick();
    check("t6_still0",  32'(bb.gnt),    32'h1);
    check("t6_still0_id", 32'(bb.gnt_id), 32'h0);
    bb.req = 4'b0010;
    tick();
    check("t6_gap_gnt",  32'(bb.gnt),  32'h0);
    check("t6_gap_busy", 32'(bb.busy), 32'h1);
    tick();
    check("t6_gnt1", 32'(bb.gnt),    32'h2);
    check("t6_id1",  32'(bb.gnt_id), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
